// File: rtl/input_pkg.sv
// Shared definitions for the button input path: direction codes,
// event word layout and cursor grid size.
package input_pkg;

   typedef enum logic [1:0] {
      DIR_R = 2'd0,
      DIR_L = 2'd1,
      DIR_U = 2'd2,
      DIR_D = 2'd3
   } dir_e;

   localparam int GRID_DIM      = 4;
   localparam int GRID_W        = $clog2(GRID_DIM);

   localparam int EVT_DIR_LSB   = 0;
   localparam int EVT_COL_LSB   = 2;
   localparam int EVT_ROW_LSB   = 4;
   localparam int EVT_VALID_BIT = 31;

   // Packs an accepted press into the 32-bit event word seen by software.
   function automatic logic [31:0] make_event(dir_e dir, logic [GRID_W-1:0] col,
                                              logic [GRID_W-1:0] row);
      logic [31:0] w;
      w                        = '0;
      w[EVT_DIR_LSB +: 2]      = dir;
      w[EVT_COL_LSB +: GRID_W] = col;
      w[EVT_ROW_LSB +: GRID_W] = row;
      w[EVT_VALID_BIT]         = 1'b1;
      return w;
   endfunction

endpackage

// File: rtl/btn_debounce.sv
// Two-flop synchronizer plus mismatch-count debouncer for one raw button.
// `press` is a one-cycle registered pulse on each debounced 0->1 edge.
module btn_debounce #(
   parameter int DEBOUNCE_CYCLES = 500000
) (
   input  logic clock,
   input  logic reset,
   input  logic raw,
   output logic level,
   output logic press
);

   localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

   logic          r_sync1;
   logic          r_sync2;
   logic          r_level;
   logic          r_press;
   logic [CW-1:0] r_cnt;

   // Synchronize, count consecutive mismatches, flip the level once the count is full.
   always_ff @(posedge clock) begin
      if (reset) begin
         r_sync1 <= 1'b0;
         r_sync2 <= 1'b0;
         r_level <= 1'b0;
         r_press <= 1'b0;
         r_cnt   <= '0;
      end else begin
         r_sync1 <= raw;
         r_sync2 <= r_sync1;
         r_press <= 1'b0;
         if (r_sync2 == r_level) begin
            r_cnt <= '0;
         end else if (r_cnt == CW'(DEBOUNCE_CYCLES)) begin
            r_level <= r_sync2;
            r_press <= r_sync2;
            r_cnt   <= '0;
         end else begin
            r_cnt <= r_cnt + 1'b1;
         end
      end
   end

   assign level = r_level;
   assign press = r_press;

endmodule

// File: rtl/button_event_queue.sv
// Debounces the four board buttons, moves the 4x4 grid cursor on each
// accepted press and queues an event word for the processor to pop.
module button_event_queue
   import input_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = 500000,
   parameter int FIFO_DEPTH      = 4,
   parameter int X0              = 80,
   parameter int Y0              = 0,
   parameter int BLOCK_W         = 120,
   parameter int BLOCK_H         = 120
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        BTNR,
   input  logic        BTNL,
   input  logic        BTNU,
   input  logic        BTND,
   output logic [9:0]  block_x,
   output logic [8:0]  block_y,
   input  logic        rd_en,
   output logic        rd_valid,
   output logic [31:0] rd_data,
   output logic        overflow,
   input  logic        clr_overflow
);

   localparam int AW = $clog2(FIFO_DEPTH);

   logic [3:0]        w_raw;
   logic [3:0]        w_level;
   logic [3:0]        w_press;
   logic [3:0]        w_evt;

   logic              w_push;
   dir_e              w_dir;
   logic [GRID_W-1:0] w_col;
   logic [GRID_W-1:0] w_row;
   logic [31:0]       w_event;
   logic              w_pop;
   logic              w_full;
   logic              w_write;

   logic [GRID_W-1:0] r_col;
   logic [GRID_W-1:0] r_row;
   logic [31:0]       r_mem [FIFO_DEPTH];
   logic [AW-1:0]     r_wr;
   logic [AW-1:0]     r_rd;
   logic [AW:0]       r_count;
   logic              r_overflow;

   // Bit index matches the direction code: R=0, L=1, U=2, D=3.
   assign w_raw = {BTND, BTNU, BTNL, BTNR};

   for (genvar g = 0; g < 4; g++) begin : g_btn
      btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb (
         .clock (clock),
         .reset (reset),
         .raw   (w_raw[g]),
         .level (w_level[g]),
         .press (w_press[g])
      );
   end

   // A press pulse coincides with its debounced level being high.
   assign w_evt = w_press & w_level;

   // Priority select R > L > U > D and the resulting cursor position.
   always_comb begin
      w_push = 1'b1;
      w_dir  = DIR_R;
      w_col  = r_col;
      w_row  = r_row;
      if (w_evt[DIR_R]) begin
         w_col = r_col + 1'b1;
      end else if (w_evt[DIR_L]) begin
         w_dir = DIR_L;
         w_col = r_col - 1'b1;
      end else if (w_evt[DIR_U]) begin
         w_dir = DIR_U;
         w_row = r_row - 1'b1;
      end else if (w_evt[DIR_D]) begin
         w_dir = DIR_D;
         w_row = r_row + 1'b1;
      end else begin
         w_push = 1'b0;
      end
   end

   assign w_event = make_event(w_dir, w_col, w_row);
   assign w_pop   = rd_en && (r_count != '0);
   assign w_full  = (r_count == (AW+1)'(FIFO_DEPTH));
   // A simultaneous pop frees the head slot, so a full queue can still accept.
   assign w_write = w_push && (!w_full || w_pop);

   // Cursor moves on every accepted press, even when its event is dropped.
   always_ff @(posedge clock) begin
      if (reset) begin
         r_col <= '0;
         r_row <= '0;
      end else if (w_push) begin
         r_col <= w_col;
         r_row <= w_row;
      end
   end

   // Event storage; contents are don't-care while the slot is unoccupied.
   always_ff @(posedge clock) begin
      if (w_write) begin
         r_mem[r_wr] <= w_event;
      end
   end

   // Queue pointers, occupancy and the sticky overflow flag.
   always_ff @(posedge clock) begin
      if (reset) begin
         r_wr       <= '0;
         r_rd       <= '0;
         r_count    <= '0;
         r_overflow <= 1'b0;
      end else begin
         if (w_write) begin
            r_wr <= r_wr + 1'b1;
         end
         if (w_pop) begin
            r_rd <= r_rd + 1'b1;
         end
         case ({w_write, w_pop})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase
         if (w_push && w_full && !w_pop) begin
            r_overflow <= 1'b1;
         end else if (clr_overflow) begin
            r_overflow <= 1'b0;
         end
      end
   end

   assign rd_valid = (r_count != '0);
   assign rd_data  = rd_valid ? r_mem[r_rd] : '0;
   assign overflow = r_overflow;
   assign block_x  = 10'(X0 + 32'(r_col) * BLOCK_W);
   assign block_y  = 9'(Y0 + 32'(r_row) * BLOCK_H);

endmodule

// File: tb/tb_button_event_queue.sv
// Directed and randomized button episodes checked against a queue-based
// model of cursor, event queue and overflow flag.
module tb_button_event_queue;

   logic        clock;
   logic        reset;
   logic        BTNR, BTNL, BTNU, BTND;
   logic [9:0]  block_x;
   logic [8:0]  block_y;
   logic        rd_en;
   logic        rd_valid;
   logic [31:0] rd_data;
   logic        overflow;
   logic        clr_overflow;

   button_event_queue #(
      .DEBOUNCE_CYCLES (4),
      .FIFO_DEPTH      (4),
      .X0              (80),
      .Y0              (0),
      .BLOCK_W         (120),
      .BLOCK_H         (120)
   ) dut (
      .clock        (clock),
      .reset        (reset),
      .BTNR         (BTNR),
      .BTNL         (BTNL),
      .BTNU         (BTNU),
      .BTND         (BTND),
      .block_x      (block_x),
      .block_y      (block_y),
      .rd_en        (rd_en),
      .rd_valid     (rd_valid),
      .rd_data      (rd_data),
      .overflow     (overflow),
      .clr_overflow (clr_overflow)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   int          checks = 0;
   int          errors = 0;
   string       phase  = "init";

   // Reference model state
   int          m_col  = 0;
   int          m_row  = 0;
   bit          m_ovf  = 1'b0;
   logic [31:0] m_q [$];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s/%s observed=%h expected=%h", phase, tag, obs, exp);
      end
   endtask

   task automatic check_all();
      chk("block_x",  32'(block_x),  32'(80 + 120 * m_col));
      chk("block_y",  32'(block_y),  32'(120 * m_row));
      chk("rd_valid", 32'(rd_valid), 32'(m_q.size() > 0));
      chk("rd_data",  rd_data,       (m_q.size() > 0) ? m_q[0] : 32'h0);
      chk("overflow", 32'(overflow), 32'(m_ovf));
   endtask

   // One clock: drive inputs on the falling edge, update the model at the
   // rising edge, compare 1 time unit later. win >= 0 means a press of that
   // direction lands on this edge.
   task automatic tick(input logic [3:0] raw, input bit rd, input bit clr, input int win);
      bit pop_ok;
      bit new_ovf;
      @(negedge clock);
      reset        = 1'b0;
      BTNR         = raw[0];
      BTNL         = raw[1];
      BTNU         = raw[2];
      BTND         = raw[3];
      rd_en        = rd;
      clr_overflow = clr;
      @(posedge clock);
      pop_ok  = rd && (m_q.size() > 0);
      new_ovf = 1'b0;
      if (pop_ok) m_q.delete(0);
      if (win >= 0) begin
         case (win)
            0:       m_col = (m_col + 1) % 4;
            1:       m_col = (m_col + 3) % 4;
            2:       m_row = (m_row + 3) % 4;
            default: m_row = (m_row + 1) % 4;
         endcase
         if (m_q.size() >= 4) new_ovf = 1'b1;
         else m_q.push_back(32'h8000_0000 | 32'(m_row * 16 + m_col * 4 + win));
      end
      m_ovf = (m_ovf && !clr) || new_ovf;
      #1;
      check_all();
   endtask

   // Buttons go high together for their own hold lengths (0 = untouched).
   // A button held at least 5 cycles (DEBOUNCE_CYCLES+1) is accepted, and
   // accepted presses land 7 edges after the first sampling edge.
   task automatic episode(input int hr, input int hl, input int hu, input int hd,
                          input int pop_at, input int pop_pct, input int clr_pct);
      int h [4];
      int win;
      h   = '{hr, hl, hu, hd};
      win = -1;
      for (int i = 3; i >= 0; i--) if (h[i] >= 5) win = i;
      for (int c = 1; c <= 20; c++) begin
         logic [3:0] raw;
         bit rd;
         bit clr;
         for (int i = 0; i < 4; i++) raw[i] = (c <= h[i]);
         rd  = (c == pop_at) || ($urandom_range(99) < pop_pct);
         clr = ($urandom_range(99) < clr_pct);
         tick(raw, rd, clr, (c == 8) ? win : -1);
      end
   endtask

   // Buttons are left untouched so one can be held across reset.
   task automatic do_reset();
      @(negedge clock);
      reset        = 1'b1;
      rd_en        = 1'b0;
      clr_overflow = 1'b0;
      repeat (2) @(posedge clock);
      m_col = 0;
      m_row = 0;
      m_ovf = 1'b0;
      m_q.delete();
      #1;
      check_all();
   endtask

   initial begin
      reset        = 1'b1;
      BTNR         = 1'b0;
      BTNL         = 1'b0;
      BTNU         = 1'b0;
      BTND         = 1'b0;
      rd_en        = 1'b0;
      clr_overflow = 1'b0;

      phase = "reset";
      do_reset();

      phase = "latency";
      episode(10, 0, 0, 0, 0, 0, 0);

      phase = "glitch";
      episode(0, 0, 3, 0, 0, 0, 0);
      episode(0, 0, 4, 0, 0, 0, 0);

      phase = "wrap";
      do_reset();
      repeat (4) episode(0, 6, 0, 0, 0, 0, 0);
      repeat (4) tick(4'b0000, 1'b1, 1'b0, -1);
      episode(0, 0, 6, 0, 0, 0, 0);
      chk("wrap_evt", rd_data, 32'h8000_0032);
      tick(4'b0000, 1'b1, 1'b0, -1);

      phase = "overflow";
      do_reset();
      repeat (5) episode(0, 0, 0, 6, 0, 0, 0);
      tick(4'b0000, 1'b0, 1'b1, -1);
      repeat (4) tick(4'b0000, 1'b1, 1'b0, -1);

      phase = "simul";
      repeat (4) episode(0, 0, 6, 0, 0, 0, 0);
      episode(6, 0, 0, 6, 8, 0, 0);
      repeat (4) tick(4'b0000, 1'b1, 1'b0, -1);

      phase = "reset_mid";
      repeat (2) episode(7, 0, 0, 0, 0, 0, 0);
      repeat (3) tick(4'b0010, 1'b0, 1'b0, -1);
      do_reset();
      episode(0, 12, 0, 0, 0, 0, 0);
      chk("reset_mid_evt", rd_data, 32'h8000_000D);

      phase = "random";
      repeat (30) begin
         int hh [4];
         for (int i = 0; i < 4; i++)
            hh[i] = ($urandom_range(2) == 0) ? int'($urandom_range(9, 1)) : 0;
         episode(hh[0], hh[1], hh[2], hh[3], 0, 30, 10);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
